// File: rtl/sha3_row_bus_pkg.sv
// Shared constants, beat-count helper and FSM state type for the SHA3 row-bus serializer.
package sha3_row_bus_pkg;

    localparam int unsigned SHA3_ROWS  = 5;
    localparam int unsigned SHA3_LANES = 5;

    typedef enum logic {
        ROWSER_IDLE,
        ROWSER_DRAIN
    } rowser_state_e;

    function automatic int unsigned sha3_beats(input int unsigned rows_per_beat);
        return (SHA3_ROWS + rows_per_beat - 1) / rows_per_beat;
    endfunction

endpackage

// File: rtl/sha3_row_slot.sv
// One full-state capture register with an occupied flag and load/free strobes.
module sha3_row_slot
    import sha3_row_bus_pkg::*;
#(
    parameter int unsigned LANE_W = 64
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            load,
    input  logic                                            free,
    input  logic [SHA3_ROWS-1:0][SHA3_LANES-1:0][LANE_W-1:0] rows_in,
    output logic [SHA3_ROWS-1:0][SHA3_LANES-1:0][LANE_W-1:0] rows_out,
    output logic                                            occupied
);

    logic                                            occ_q, occ_d;
    logic [SHA3_ROWS-1:0][SHA3_LANES-1:0][LANE_W-1:0] data_q, data_d;

    always_comb begin
        occ_d  = occ_q;
        data_d = data_q;
        if (load) begin
            occ_d  = 1'b1;
            data_d = rows_in;
        end else if (free) begin
            occ_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= 1'b0;
            data_q <= '0;
        end else begin
            occ_q  <= occ_d;
            data_q <= data_d;
        end
    end

    assign rows_out = data_q;
    assign occupied = occ_q;

endmodule

// File: rtl/sha3_row_bus_serializer.sv
// Buffers a full 5x5 Keccak state and replays it as ready/valid row-group beats.
// Define SHA3_ROWSER_PINGPONG_EN for two capture slots (capture during drain, no bubble).
module sha3_row_bus_serializer
    import sha3_row_bus_pkg::*;
#(
    parameter int unsigned LANE_W        = 64,
    parameter int unsigned ROWS_PER_BEAT = 1
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                in_sample,
    input  logic [SHA3_ROWS-1:0][SHA3_LANES-1:0][LANE_W-1:0]     in_rows,
    output logic                                                in_ready,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [ROWS_PER_BEAT-1:0][SHA3_LANES-1:0][LANE_W-1:0] out_rows,
    output logic [2:0]                                          out_row_idx,
    output logic [ROWS_PER_BEAT-1:0]                            out_row_mask,
    output logic                                                out_last,
    output logic                                                overflow
);

    localparam int unsigned BEATS = sha3_beats(ROWS_PER_BEAT);

    typedef logic [SHA3_ROWS-1:0][SHA3_LANES-1:0][LANE_W-1:0] rows_t;

    rowser_state_e state_q, state_d;
    logic [2:0]    b_q, b_d;
    logic          overflow_q, overflow_d;
    logic          capture, accept, last_beat, release_last, pending;
    rows_t         cur_rows;

    assign capture      = in_sample && in_ready;
    assign accept       = out_valid && out_ready;
    assign last_beat    = (b_q == 3'(BEATS - 1));
    assign release_last = accept && last_beat;

`ifdef SHA3_ROWSER_PINGPONG_EN
    logic [1:0] slot_occ, slot_load, slot_free;
    rows_t      slot_rows [2];
    logic       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

    for (genvar i = 0; i < 2; i++) begin : g_slot
        sha3_row_slot #(.LANE_W(LANE_W)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (slot_load[i]),
            .free     (slot_free[i]),
            .rows_in  (in_rows),
            .rows_out (slot_rows[i]),
            .occupied (slot_occ[i])
        );
    end

    // Slots form a two-entry ring: write pointer always names the free slot when in_ready.
    always_comb begin
        slot_load           = '0;
        slot_free           = '0;
        slot_load[wr_ptr_q] = capture;
        slot_free[rd_ptr_q] = release_last;
        wr_ptr_d            = wr_ptr_q ^ capture;
        rd_ptr_d            = rd_ptr_q ^ release_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign in_ready = ~&slot_occ;
    assign cur_rows = slot_rows[rd_ptr_q];
    assign pending  = slot_occ[~rd_ptr_q] | capture;
`else
    logic slot_occ;

    sha3_row_slot #(.LANE_W(LANE_W)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (capture),
        .free     (release_last),
        .rows_in  (in_rows),
        .rows_out (cur_rows),
        .occupied (slot_occ)
    );

    assign in_ready = ~slot_occ;
    assign pending  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        overflow_d = overflow_q | (in_sample & ~in_ready);
        case (state_q)
            ROWSER_IDLE: begin
                if (capture) begin
                    state_d = ROWSER_DRAIN;
                    b_d     = '0;
                end
            end
            ROWSER_DRAIN: begin
                if (accept) begin
                    if (last_beat) begin
                        b_d = '0;
                        if (!pending) state_d = ROWSER_IDLE;
                    end else begin
                        b_d = b_q + 3'd1;
                    end
                end
            end
            default: state_d = ROWSER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ROWSER_IDLE;
            b_q        <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid   = (state_q == ROWSER_DRAIN);
    assign out_row_idx = b_q * 3'(ROWS_PER_BEAT);
    assign out_last    = out_valid && last_beat;
    assign overflow    = overflow_q;

    // Rows past the bottom of the state are padding: zero data, mask bit clear.
    for (genvar k = 0; k < ROWS_PER_BEAT; k++) begin : g_mux
        logic [3:0] row_sel;
        assign row_sel         = {1'b0, out_row_idx} + 4'(k);
        assign out_row_mask[k] = out_valid && (row_sel < 4'(SHA3_ROWS));
        assign out_rows[k]     = out_row_mask[k] ? cur_rows[row_sel[2:0]] : '0;
    end

endmodule
